struct_array_packer: RTL
========================

// Module: struct_array_packer
// PURPOSE
//   Upstream feeder for the struct-array unpacker. Collects a stream of
//   {a,b,c} records over a valid/ready handshake and assembles them into one
//   packed array word (DEPTH entries, entry i at bits [i*ENTRY_W +: ENTRY_W]).
//   Emits each frame on a valid/ready output that drives the unpacker's input bus.
// PARAMETERS
//   DEPTH    8   entries per frame (>=2); index width IDX_W = $clog2(DEPTH)
//   A_W      1   width of field a (entry MSBs)
//   B_W      4   width of field b (middle)
//   C_W      2   width of field c (entry LSBs)
//   ENTRY_W  A_W+B_W+C_W (derived, 7); frame width FRAME_W = DEPTH*ENTRY_W (56)
// PORTS
//   clk        in   1                 rising-edge clock
//   rst        in   1                 async active-high reset
//   in_valid   in   1                 record offered
//   in_ready   out  1                 packer can accept a record
//   in_a       in   A_W               field a
//   in_b       in   B_W               field b
//   in_c       in   C_W               field c
//   in_last    in   1                 record closes the frame early
//   out_valid  out  1                 frame available
//   out_ready  in   1                 consumer takes frame
//   out_data   out  FRAME_W           packed frame
//   out_count  out  IDX_W+1           valid entries in frame (1..DEPTH)
// BEHAVIOUR
//   - Entry layout: {a,b,c}; a at the entry MSB, c at the entry LSB.
//   - Transfer = valid & ready at a rising clk edge. Inputs are ignored otherwise.
//   - Reset (async): state=FILL, wr_idx=0, frame reg=0, out_valid=0,
//     out_data=0, out_count=0. in_ready is 1 from the first edge after release.
//   - FSM FILL: in_ready=1, out_valid=0. An accepted record is written to slot
//     wr_idx and wr_idx increments. If wr_idx==DEPTH-1 or in_last=1, go to HOLD;
//     out_count=wr_idx+1.
//   - FSM HOLD: in_ready=0, out_valid=1. out_data/out_count are stable until
//     accepted. On out_ready: frame reg cleared to 0, wr_idx=0, go to FILL.
//   - Latency: the frame is valid the cycle after the closing record's edge.
//     Min frame period = records + 1 cycle (the HOLD cycle).
//   - Early close: unwritten slots read as 0. in_last on slot DEPTH-1 is
//     redundant: no extra frame, no error.
//   - out_ready while out_valid=0 has no effect. in_valid in HOLD is not consumed.
//   - Reset mid-frame: the partial frame is discarded; the next record goes to slot 0.
//   - wr_idx never exceeds DEPTH-1. There is no wrap without a frame emit.
// CONFIGURATION
//   PACKER_DOUBLE_BUF_EN defined: two frame buffers (fill and hold).
//   - On a close, the fill buffer moves to hold if hold is empty or is
//     handshaken in the same cycle. The fill buffer then clears, and FILL continues.
//   - in_ready drops only when the hold buffer is occupied, not being taken,
//     and the fill buffer is also complete.
//   - A back-to-back stream with out_ready=1 sees in_ready held at 1.
//   - Reset clears both buffers.
//   PACKER_DOUBLE_BUF_EN undefined: single buffer, FILL/HOLD as above.
// TESTING
//   1 Full frame: 8 records (a,b,c), slot0..7 = (0,1010,00)(1,1100,11)
//     (0,1000,10)(0,1110,01)(0,0111,11)(1,0111,11)(1,0110,11)(0,1111,01),
//     out_ready=1 -> out_data=56'h7B6EF9F728B9A8, out_count=8, out_valid for 1 cycle.
//   2 Early close: 3 records, 3rd with in_last=1 -> out_count=3,
//     out_data[55:21]=0, low 21 bits match the records.
//   3 Backpressure: frame complete, out_ready=0 for 5 cycles -> out_data stable,
//     in_ready=0 (single buffer). out_ready=1 -> next cycle in_ready=1, slot 0 next.
//   4 Reset mid-frame: 4 records, pulse rst -> out_valid=0, out_count=0.
//     The next 8 records produce a frame built only from them.
//   5 Gapped input: in_valid toggles 1/0 over 8 records -> same 56'h7B6EF9F728B9A8.
//     No record is dropped or duplicated.
//   6 PACKER_DOUBLE_BUF_EN: 16 back-to-back records, out_ready=1 -> in_ready
//     never 0, two frames emitted 8 cycles apart.

Source files
------------

// File: rtl/struct_array_packer.sv
// rtl/struct_array_packer.sv - packs a stream of {a,b,c} records into one DEPTH-entry frame word
//
// Purpose : collects {a,b,c} records over a valid/ready handshake and emits
//           them as one packed frame (entry i at bits [i*ENTRY_W +: ENTRY_W],
//           field a at the entry MSB, field c at the entry LSB).
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready, in_a, in_b, in_c, in_last  - record input
//           out_valid/out_ready, out_data, out_count       - frame output
// Config  : PACKER_DOUBLE_BUF_EN - separate fill and hold buffers so records
//           keep flowing while a finished frame waits for the consumer.
//           Undefined: single buffer with a FILL/HOLD state machine.

module struct_array_packer #(
    parameter  int DEPTH   = 8,
    parameter  int A_W     = 1,
    parameter  int B_W     = 4,
    parameter  int C_W     = 2,
    localparam int ENTRY_W = A_W + B_W + C_W,
    localparam int FRAME_W = DEPTH * ENTRY_W,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    input  logic [C_W-1:0]     in_c,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic [IDX_W:0]     out_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] entry;
    assign entry = {in_a, in_b, in_c};

    // Holds in_ready low until the first edge after reset release.
    logic started_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

`ifdef PACKER_DOUBLE_BUF_EN

    logic [FRAME_W-1:0] fill_q, fill_d, fill_w;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d, idx_w;
    logic               fill_full_q, fill_full_d;
    logic [IDX_W:0]     fill_cnt_q, fill_cnt_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic [IDX_W:0]     hold_cnt_q, hold_cnt_d;
    logic               hold_valid_q, hold_valid_d;
    logic               take, accept, moved, closing;
    logic [IDX_W:0]     cnt_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q       <= '0;
            wr_idx_q     <= '0;
            fill_full_q  <= 1'b0;
            fill_cnt_q   <= '0;
            hold_q       <= '0;
            hold_cnt_q   <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            wr_idx_q     <= wr_idx_d;
            fill_full_q  <= fill_full_d;
            fill_cnt_q   <= fill_cnt_d;
            hold_q       <= hold_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_comb begin
        fill_d       = fill_q;
        wr_idx_d     = wr_idx_q;
        fill_full_d  = fill_full_q;
        fill_cnt_d   = fill_cnt_q;
        hold_d       = hold_q;
        hold_cnt_d   = hold_cnt_q;
        hold_valid_d = hold_valid_q;
        moved        = 1'b0;
        closing      = 1'b0;
        cnt_w        = '0;
        fill_w       = fill_q;
        idx_w        = wr_idx_q;

        take     = hold_valid_q & out_ready;
        // Stall only when both buffers hold finished frames and nothing drains.
        in_ready = started_q & ~(hold_valid_q & ~out_ready & fill_full_q);
        accept   = in_valid & in_ready;

        if (take) begin
            hold_valid_d = 1'b0;
            hold_d       = '0;
            hold_cnt_d   = '0;
        end

        // A completed fill buffer waiting behind hold moves up as hold drains;
        // any record accepted this cycle then starts a fresh frame at slot 0.
        if (fill_full_q && take) begin
            moved        = 1'b1;
            hold_d       = fill_q;
            hold_cnt_d   = fill_cnt_q;
            hold_valid_d = 1'b1;
            fill_full_d  = 1'b0;
            fill_cnt_d   = '0;
            fill_w       = '0;
            idx_w        = '0;
        end

        fill_d   = fill_w;
        wr_idx_d = idx_w;

        if (accept) begin
            fill_w[idx_w*ENTRY_W +: ENTRY_W] = entry;
            closing = in_last | (idx_w == LAST_IDX);
            cnt_w   = (IDX_W+1)'(idx_w) + (IDX_W+1)'(1);
            if (closing) begin
                if ((!hold_valid_q || take) && !moved) begin
                    hold_d       = fill_w;
                    hold_cnt_d   = cnt_w;
                    hold_valid_d = 1'b1;
                    fill_d       = '0;
                    wr_idx_d     = '0;
                end else begin
                    fill_d      = fill_w;
                    fill_full_d = 1'b1;
                    fill_cnt_d  = cnt_w;
                    wr_idx_d    = idx_w;
                end
            end else begin
                fill_d   = fill_w;
                wr_idx_d = idx_w + IDX_W'(1);
            end
        end
    end

    assign out_valid = hold_valid_q;
    assign out_data  = hold_q;
    assign out_count = hold_cnt_q;

`else

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            frame_q  <= '0;
            wr_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            wr_idx_q <= wr_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        wr_idx_d  = wr_idx_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = started_q;
                accept   = in_valid & started_q;
                if (accept) begin
                    frame_d[wr_idx_q*ENTRY_W +: ENTRY_W] = entry;
                    if (in_last || wr_idx_q == LAST_IDX) begin
                        // Index returns to 0 here so it never passes DEPTH-1.
                        state_d  = HOLD;
                        cnt_d    = (IDX_W+1)'(wr_idx_q) + (IDX_W+1)'(1);
                        wr_idx_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = FILL;
                    frame_d  = '0;
                    cnt_d    = '0;
                    wr_idx_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign out_data  = frame_q;
    assign out_count = cnt_q;

`endif

endmodule
